bulk_in_stream_arbiter: RTL

//  Shares the single bulk IN AXIS byte stream (s_axis_* of the bulk endpoint bridge) among
//  NUM_SRC AXIS sources in sys_clk domain. Packet-granular round-robin; optional 1-byte

---
 rtl/bulk_in_stream_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bulk_in_stream_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_SRC byte streams onto the single bulk IN
// stream, with an optional channel tag byte and forced packet splitting at MAX_PKT bytes.
module bulk_in_stream_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int MAX_PKT = 512,
  parameter int TAG_EN  = 1
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  input  logic [8*NUM_SRC-1:0] s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(MAX_PKT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state, state_d;
  logic [IW-1:0] gidx, gidx_d;
  logic [IW-1:0] last_g, last_g_d;
  logic [CW-1:0] count, count_d;
  logic          cont, cont_d;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW-1:0] cand;
  int            cand_i;
  logic          hs;
  logic [7:0]    src_data [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_data[i] = s_axis_tdata[8*i +: 8];
  end

  // Walk downward so the nearest requester after last_g is the one that sticks.
  always_comb begin
    pick     = last_g;
    pick_vld = 1'b0;
    cand_i   = 0;
    cand     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand_i = (int'(last_g) + k) % NUM_SRC;
      cand   = IW'(cand_i);
      if (s_axis_tvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state;
    gidx_d        = gidx;
    last_g_d      = last_g;
    count_d       = count;
    cont_d        = cont;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    hs            = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick;
          cont_d  = 1'b0;
          count_d = '0;
          state_d = (TAG_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {cont, 3'b000, 4'(gidx)};
        if (m_axis_tready) begin
          count_d = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        m_axis_tvalid       = s_axis_tvalid[gidx];
        m_axis_tdata        = src_data[gidx];
        m_axis_tlast        = s_axis_tlast[gidx] | (count == CNT_LAST);
        s_axis_tready[gidx] = m_axis_tready;
        hs                  = s_axis_tvalid[gidx] & m_axis_tready;
        if (hs) begin
          if (m_axis_tlast) begin
            count_d = '0;
            if (s_axis_tlast[gidx]) begin
              state_d  = IDLE;
              last_g_d = gidx;
              cont_d   = 1'b0;
            end else begin
              // Forced split: same source keeps the bus into the next USB packet.
              cont_d  = 1'b1;
              state_d = (TAG_EN != 0) ? HDR : DATA;
            end
          end else begin
            count_d = count + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      gidx   <= '0;
      last_g <= IW'(NUM_SRC - 1);
      count  <= '0;
      cont   <= 1'b0;
    end else begin
      state  <= state_d;
      gidx   <= gidx_d;
      last_g <= last_g_d;
      count  <= count_d;
      cont   <= cont_d;
    end
  end

  assign busy_o  = (state != IDLE);
  assign grant_o = busy_o ? (NUM_SRC'(1) << gidx) : '0;

endmodule
